alu_issue_seq: RTL and testbench

- Upstream issue stage for the 4-bit ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- It drives the ALU's valid_in/a/b/ctl/cin, one op per cycle.
- It owns the architectural carry flag register that feeds ALU cin. The register is updated from the ALU's registered carry output.
- Carry-consuming ops (ADC ctl=0100, SBB ctl=0110) are held at the FIFO head until the previous result's carry has landed.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 64 ++++++
 rtl/alu_issue_seq.sv | 115 +++++++++++
 tb/tb_alu_issue_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, command record and opcode classification helpers
// for the 4-bit ALU issue path.
package alu_pkg;

   localparam logic [3:0] OP_PASS = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_ADC  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_SBB  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1000;
   localparam logic [3:0] OP_SHL  = 4'b1001;
   localparam logic [3:0] OP_SHR  = 4'b1010;
   localparam logic [3:0] OP_INC  = 4'b1011;
   localparam logic [3:0] OP_DEC  = 4'b1100;
   localparam logic [3:0] OP_CMP  = 4'b1101;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] ctl;
   } cmd_t;

   // 1110 and 1111 are the only unassigned encodings
   function automatic logic is_legal(input logic [3:0] ctl);
      return !(ctl[3] && ctl[2] && ctl[1]);
   endfunction

   function automatic logic uses_carry(input logic [3:0] ctl);
      return (ctl == OP_ADC) || (ctl == OP_SBB);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Power-of-two synchronous command FIFO with occupancy count. The head entry
// is visible combinationally so the issue logic can inspect it before popping.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  cmd_t                     wdata,
   output cmd_t                     rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   cmd_t            mem [DEPTH];
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic            wr_en;
   logic            rd_en;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr_reg];
   assign count = count_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap on their own
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue stage for the 4-bit ALU: buffers commands, issues one per cycle and
// owns the carry flag. Macro ALU_ISSUE_CARRY_BYPASS_EN forwards the ALU carry.
module alu_issue_seq
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ERR_W      = 8
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [3:0]                    cmd_a,
   input  logic [3:0]                    cmd_b,
   input  logic [3:0]                    cmd_ctl,
   input  logic                          clr_carry,
   output logic                          alu_valid_in,
   output logic [3:0]                    alu_a,
   output logic [3:0]                    alu_b,
   output logic [3:0]                    alu_ctl,
   output logic                          alu_cin,
   input  logic                          alu_valid_out,
   input  logic                          alu_carry,
   output logic                          carry_flag,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [ERR_W-1:0]              err_cnt,
   output logic                          busy
);

   cmd_t             in_cmd;
   cmd_t             head_cmd;
   cmd_t             issue_reg;
   logic             fifo_full;
   logic             fifo_empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic             carry_ok;
   logic             valid_reg;
   logic             pending_reg;
   logic             carry_flag_reg;
   logic [ERR_W-1:0] err_cnt_reg;

   assign in_cmd    = '{a: cmd_a, b: cmd_b, ctl: cmd_ctl};
   assign cmd_ready = !reset && !fifo_full;
   assign accept    = cmd_valid && cmd_ready;
   assign push      = accept && is_legal(cmd_ctl);

   alu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (in_cmd),
      .rdata (head_cmd),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef ALU_ISSUE_CARRY_BYPASS_EN
   // The forwarded carry covers the response cycle, so only the op in the
   // issue register has to drain before a carry consumer may follow.
   assign carry_ok = !valid_reg;
   assign alu_cin  = (alu_valid_out && pending_reg && !clr_carry) ? alu_carry : carry_flag_reg;
`else
   assign carry_ok = !valid_reg && !pending_reg;
   assign alu_cin  = carry_flag_reg;
`endif

   assign pop = !fifo_empty && (!uses_carry(head_cmd.ctl) || carry_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg   <= 1'b0;
         issue_reg   <= '0;
         pending_reg <= 1'b0;
      end else begin
         valid_reg   <= pop;
         pending_reg <= valid_reg;
         if (pop) begin
            issue_reg <= head_cmd;
         end
      end
   end

   // A response only counts when this stage is expecting one
   always_ff @(posedge clk) begin
      if (reset || clr_carry) begin
         carry_flag_reg <= 1'b0;
      end else if (alu_valid_out && pending_reg) begin
         carry_flag_reg <= alu_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_reg <= '0;
      end else if (accept && !is_legal(cmd_ctl) && (err_cnt_reg != '1)) begin
         err_cnt_reg <= err_cnt_reg + ERR_W'(1);
      end
   end

   assign alu_valid_in = valid_reg;
   assign alu_a        = issue_reg.a;
   assign alu_b        = issue_reg.b;
   assign alu_ctl      = issue_reg.ctl;
   assign carry_flag   = carry_flag_reg;
   assign err_cnt      = err_cnt_reg;
   assign busy         = !fifo_empty || valid_reg || pending_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with a behavioural 1-cycle ALU model;
// a second instance with ERR_W=2 covers error-counter saturation.
module tb_alu_issue_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_valid2 = 1'b0;
   logic [3:0] cmd_a = '0;
   logic [3:0] cmd_b = '0;
   logic [3:0] cmd_ctl = '0;
   logic       clr_carry = 1'b0;

   logic       cmd_ready, alu_valid_in, alu_cin, carry_flag, busy;
   logic [3:0] alu_a, alu_b, alu_ctl;
   logic [2:0] fifo_count;
   logic [7:0] err_cnt;

   logic       cmd_ready2, alu_valid_in2, alu_cin2, carry_flag2, busy2;
   logic [3:0] alu_a2, alu_b2, alu_ctl2;
   logic [2:0] fifo_count2;
   logic [1:0] err_cnt2;

   logic       alu_vo = 1'b0;
   logic       alu_c = 1'b0;
   logic [3:0] alu_res = '0;

   always #5 clk = ~clk;

   alu_issue_seq #(.FIFO_DEPTH(4), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctl(cmd_ctl), .clr_carry(clr_carry),
      .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
      .alu_cin(alu_cin), .alu_valid_out(alu_vo), .alu_carry(alu_c),
      .carry_flag(carry_flag), .fifo_count(fifo_count), .err_cnt(err_cnt), .busy(busy)
   );

   alu_issue_seq #(.FIFO_DEPTH(4), .ERR_W(2)) dut2 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctl(cmd_ctl), .clr_carry(clr_carry),
      .alu_valid_in(alu_valid_in2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctl(alu_ctl2),
      .alu_cin(alu_cin2), .alu_valid_out(1'b0), .alu_carry(1'b0),
      .carry_flag(carry_flag2), .fifo_count(fifo_count2), .err_cnt(err_cnt2), .busy(busy2)
   );

`ifdef ALU_ISSUE_CARRY_BYPASS_EN
   localparam int DEP_SPACING = 2;
   localparam int QUEUED_AT_RESET = 2;
`else
   localparam int DEP_SPACING = 3;
   localparam int QUEUED_AT_RESET = 3;
`endif

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] ctl;
      bit         chk_cin;
      bit         cin;
   } exp_t;

   exp_t sb[$];
   int   issue_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   max_count = 0;
   bit   saw_hold_block = 1'b0;
   bit   saw_issue2 = 1'b0;

   function automatic logic [4:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] ctl, input logic cin);
      case (ctl)
         4'h1:    return {1'b0, a & b};
         4'h3:    return {1'b0, a} + {1'b0, b};
         4'h4:    return {1'b0, a} + {1'b0, b} + {4'b0, cin};
         4'h5:    return {1'b0, a} - {1'b0, b};
         4'h6:    return {1'b0, a} - {1'b0, b} - {4'b0, cin};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   // Registered ALU model; deliberately ignores reset so flushed ops still answer
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      alu_vo <= alu_valid_in;
      if (alu_valid_in) begin
         {alu_c, alu_res} <= alu_eval(alu_a, alu_b, alu_ctl, alu_cin);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: every issued op must match the head of the scoreboard
   always @(negedge clk) begin
      #1;
      if (alu_valid_in2) saw_issue2 = 1'b1;
      if (!reset && alu_valid_in) begin
         issue_cyc.push_back(cyc);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue got a=%h b=%h ctl=%h exp none", alu_a, alu_b, alu_ctl);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({alu_a, alu_b, alu_ctl} !== {e.a, e.b, e.ctl}) begin
               errors++;
               $display("FAIL issue_order got a=%h b=%h ctl=%h exp a=%h b=%h ctl=%h",
                        alu_a, alu_b, alu_ctl, e.a, e.b, e.ctl);
            end
            if (e.chk_cin) check("issue_cin", alu_cin, e.cin);
         end
         $display("issue cyc=%0d a=%h b=%h ctl=%h cin=%b", cyc, alu_a, alu_b, alu_ctl, alu_cin);
      end
   end

   always @(negedge clk) begin
      #2;
      check("ready_rule", cmd_ready, (!reset && fifo_count < 3'd4));
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
   end

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ctl,
                       input bit chk, input bit cin);
      int n = 0;
      exp_t e;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_a = a;
      cmd_b = b;
      cmd_ctl = ctl;
      while (!cmd_ready && n < 100) begin
         saw_hold_block = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
      if (ctl < 4'hE) begin
         e = '{a: a, b: b, ctl: ctl, chk_cin: chk, cin: cin};
         sb.push_back(e);
      end
      $display("accept a=%h b=%h ctl=%h", a, b, ctl);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || sb.size() != 0) && n < 200);
      if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
   endtask

   logic [3:0] fill_a [8] = '{4'hF, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h2};
   logic [3:0] fill_b [8] = '{4'h1, 4'h2, 4'h1, 4'h4, 4'h2, 4'h7, 4'h3, 4'h2};
   logic [3:0] fill_c [8] = '{4'h3, 4'h4, 4'h6, 4'h4, 4'h6, 4'h4, 4'h6, 4'h4};

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("reset_ready", cmd_ready, 1'b0);
      check("reset_count", fifo_count, 3'd0);
      check("reset_valid", alu_valid_in, 1'b0);
      check("reset_regs", {alu_a, alu_b, alu_ctl}, 12'h000);
      check("reset_carry", carry_flag, 1'b0);
      check("reset_err", err_cnt, 8'd0);
      check("reset_busy", busy, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", cmd_ready, 1'b1);

      // Single op latency and busy profile
      send(4'h3, 4'h5, 4'h3, 1'b0, 1'b0);
      idle();
      check("single_no_issue_e0", alu_valid_in, 1'b0);
      check("single_count", fifo_count, 3'd1);
      @(negedge clk);
      check("single_issue_e1", alu_valid_in, 1'b1);
      check("single_busy_e1", busy, 1'b1);
      @(negedge clk);
      check("single_pulse_e2", alu_valid_in, 1'b0);
      check("single_busy_e2", busy, 1'b1);
      @(negedge clk);
      check("single_busy_e3", busy, 1'b0);
      check("single_carry", carry_flag, 1'b0);

      // Illegal opcodes are dropped and counted
      issue_cyc.delete();
      repeat (3) send(4'h1, 4'h1, 4'hF, 1'b0, 1'b0);
      idle();
      repeat (3) @(negedge clk);
      check("illegal_err", err_cnt, 8'd3);
      check("illegal_no_issue", issue_cyc.size(), 32'd0);
      check("illegal_count", fifo_count, 3'd0);
      cmd_ctl = 4'hE;
      cmd_valid2 = 1'b1;
      repeat (2) @(negedge clk);
      check("sat_err_2", err_cnt2, 2'd2);
      repeat (3) @(negedge clk);
      cmd_valid2 = 1'b0;
      check("sat_err_5", err_cnt2, 2'd3);
      check("sat_no_issue", saw_issue2, 1'b0);

      // Back-to-back non-carry ops
      issue_cyc.delete();
      repeat (4) send(4'hF, 4'h1, 4'h3, 1'b0, 1'b0);
      idle();
      wait_idle();
      check("b2b_issues", issue_cyc.size(), 32'd4);
      for (int i = 1; i < 4 && i < issue_cyc.size(); i++)
         check("b2b_spacing", issue_cyc[i] - issue_cyc[i-1], 32'd1);
      check("b2b_carry", carry_flag, 1'b1);

      // Clear, then dependent ADD -> ADC spacing and carry use
      @(negedge clk);
      clr_carry = 1'b1;
      @(negedge clk);
      clr_carry = 1'b0;
      check("clr_carry", carry_flag, 1'b0);
      issue_cyc.delete();
      send(4'hF, 4'h1, 4'h3, 1'b0, 1'b0);
      send(4'h0, 4'h0, 4'h4, 1'b1, 1'b1);
      idle();
      wait_idle();
      check("dep_issues", issue_cyc.size(), 32'd2);
      if (issue_cyc.size() == 2)
         check("dep_spacing", issue_cyc[1] - issue_cyc[0], DEP_SPACING);
      check("adc_result", alu_res, 4'h1);
      check("adc_carry", carry_flag, 1'b0);

      // Carry-op stalls fill the FIFO while cmd_valid is held
      issue_cyc.delete();
      max_count = 0;
      saw_hold_block = 1'b0;
      for (int i = 0; i < 8; i++) send(fill_a[i], fill_b[i], fill_c[i], 1'b0, 1'b0);
      idle();
      wait_idle();
      check("fill_max_count", max_count, 32'd4);
      check("fill_backpressure", saw_hold_block, 1'b1);
      check("fill_issues", issue_cyc.size(), 32'd8);

      // clr_carry beats a coincident carry=1 response
      send(4'hF, 4'h1, 4'h3, 1'b0, 1'b0);
      idle();
      @(negedge clk);
      @(negedge clk);
      check("clr_race_resp", alu_vo, 1'b1);
      clr_carry = 1'b1;
      @(negedge clk);
      clr_carry = 1'b0;
      check("clr_race_carry", carry_flag, 1'b0);
      wait_idle();

      // Reset with queued commands flushes everything
      send(4'hF, 4'h1, 4'h3, 1'b0, 1'b0);
      repeat (3) send(4'h0, 4'h0, 4'h4, 1'b0, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("flush_queued", fifo_count, QUEUED_AT_RESET);
      check("flush_carry_before", carry_flag, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("flush_count", fifo_count, 3'd0);
      check("flush_carry", carry_flag, 1'b0);
      check("flush_valid", alu_valid_in, 1'b0);
      sb.delete();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("flush_stale_resp", carry_flag, 1'b0);
      check("flush_busy", busy, 1'b0);

      check("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
